// File: rtl/fetch_cycle.sv
// fetch_cycle: IF stage with IF/ID pipeline register for a single-issue core.
// Drives one outstanding instruction-memory request at a time through a
// REQ / WAIT / HOLD state machine. A skid register holds a response that
// arrives while decode is stalled. A flush redirects PCF and squashes IF/ID.
// A flush during an outstanding request sets a kill flag, so the stale
// response is dropped when it arrives.
// Optional feature: define FETCH_PERF_EN to add the FetchCount and StallCount
// performance counters.

module fetch_cycle #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic [31:0] PCTargetE,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemReady,
  input  logic        ImemValid,
  input  logic [31:0] ImemRData,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount
`endif
);

  typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] skid_q, skid_d;
  logic        kill_q, kill_d;

  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic        load;
  logic [31:0] load_word;
  logic [31:0] flush_pc;

  // Redirect targets are forced word-aligned.
  assign flush_pc = PCTargetE & 32'hFFFF_FFFC;

  // Keep the request line low while reset is held.
  assign ImemReq  = (state_q == StReq) && !reset;
  assign ImemAddr = pcf_q;
  assign InstrD   = ifid_instr_q;
  assign PCD      = ifid_pc_q;
  assign PCPlus4D = ifid_pc4_q;
  assign ValidD   = ifid_valid_q;

  // Fetch FSM next state, PC update, kill flag and skid capture.
  always_comb begin
    state_d    = state_q;
    pcf_d      = pcf_q;
    req_addr_d = req_addr_q;
    skid_d     = skid_q;
    kill_d     = kill_q;
    load       = 1'b0;
    load_word  = skid_q;

    case (state_q)
      StReq: begin
        if (ImemReady) begin
          state_d    = StWait;
          req_addr_d = pcf_q;
          // A request accepted in the same cycle as a flush is already stale.
          kill_d     = FlushD;
        end
      end
      StWait: begin
        if (ImemValid) begin
          if (kill_q || FlushD) begin
            state_d = StReq;
            kill_d  = 1'b0;
          end else if (!StallD) begin
            load      = 1'b1;
            load_word = ImemRData;
            pcf_d     = pcf_q + 32'd4;
            state_d   = StReq;
          end else begin
            skid_d  = ImemRData;
            state_d = StHold;
          end
        end else if (FlushD) begin
          kill_d = 1'b1;
        end
      end
      StHold: begin
        if (FlushD) begin
          state_d = StReq;
        end else if (!StallD) begin
          load      = 1'b1;
          load_word = skid_q;
          pcf_d     = pcf_q + 32'd4;
          state_d   = StReq;
        end
      end
      default: state_d = StReq;
    endcase

    if (FlushD) pcf_d = flush_pc;
  end

  // IF/ID next state: flush beats stall; a stall holds; otherwise load or bubble.
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    if (FlushD) begin
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (load) begin
      ifid_instr_d = load_word;
      ifid_pc_d    = req_addr_q;
      ifid_pc4_d   = req_addr_q + 32'd4;
      ifid_valid_d = 1'b1;
    end else if (!StallD) begin
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end
  end

  // Fetch control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StReq;
      pcf_q      <= RESET_PC;
      req_addr_q <= 32'd0;
      skid_q     <= 32'd0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcf_q      <= pcf_d;
      req_addr_q <= req_addr_d;
      skid_q     <= skid_d;
      kill_q     <= kill_d;
    end
  end

  // IF/ID pipeline registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= 32'd0;
      ifid_pc4_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, stall_count_q;

  assign FetchCount = fetch_count_q;
  assign StallCount = stall_count_q;

  // Performance counters: IF/ID loads and decode-stall cycles, wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      if (load)   fetch_count_q <= fetch_count_q + 32'd1;
      if (StallD) stall_count_q <= stall_count_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_cycle.sv
// Testbench for fetch_cycle: directed cycle-by-cycle stimulus with a
// scoreboard of expected IF/ID loads, plus a second instance with
// RESET_PC = 0xFFFF_FFFC to cover PC wrap-around.
// Covers the FETCH_PERF_EN counters when that macro is defined.

module tb_fetch_cycle;

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallD, FlushD, ImemReady, ImemValid;
  logic [31:0] PCTargetE, ImemRData;
  logic        ImemReq, ValidD;
  logic [31:0] ImemAddr, InstrD, PCD, PCPlus4D;
  logic        ImemReq2, ValidD2;
  logic [31:0] ImemAddr2, InstrD2, PCD2, PCPlus4D2;
`ifdef FETCH_PERF_EN
  logic [31:0] FetchCount, StallCount, FetchCount2, StallCount2;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_fetch = 0;
  int   exp_stall = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic        prev_valid = 1'b0;
  logic [31:0] prev_pcd   = 32'd0;

  always #5 clk = ~clk;

  fetch_cycle dut (
    .clk       (clk),
    .reset     (reset),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCTargetE (PCTargetE),
    .ImemReq   (ImemReq),
    .ImemAddr  (ImemAddr),
    .ImemReady (ImemReady),
    .ImemValid (ImemValid),
    .ImemRData (ImemRData),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
`ifdef FETCH_PERF_EN
    ,
    .FetchCount(FetchCount),
    .StallCount(StallCount)
`endif
  );

  fetch_cycle #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk       (clk),
    .reset     (reset),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCTargetE (PCTargetE),
    .ImemReq   (ImemReq2),
    .ImemAddr  (ImemAddr2),
    .ImemReady (ImemReady),
    .ImemValid (ImemValid),
    .ImemRData (ImemRData),
    .InstrD    (InstrD2),
    .PCD       (PCD2),
    .PCPlus4D  (PCPlus4D2),
    .ValidD    (ValidD2)
`ifdef FETCH_PERF_EN
    ,
    .FetchCount(FetchCount2),
    .StallCount(StallCount2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then advance to just after the next rising edge.
  task automatic cyc(input logic rdy, input logic vld, input logic [31:0] rd,
                     input logic stl, input logic fl, input logic [31:0] tgt);
    ImemReady = rdy;
    ImemValid = vld;
    ImemRData = rd;
    StallD    = stl;
    FlushD    = fl;
    PCTargetE = tgt;
    if (stl) exp_stall++;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_load(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    sb.push_back(e);
    exp_fetch++;
  endtask

  // Monitor: each new valid IF/ID entry is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      if (ValidD && (!prev_valid || PCD != prev_pcd)) begin
        if (sb.size() == 0) begin
          check("unexpected_load", {31'd0, ValidD}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("sb_instr", InstrD, mon_e.instr);
          check("sb_pcd", PCD, mon_e.pc);
          check("sb_pcplus4", PCPlus4D, mon_e.pc + 32'd4);
        end
      end
      prev_valid <= ValidD;
      prev_pcd   <= PCD;
    end else begin
      prev_valid <= 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    StallD = 1'b0; FlushD = 1'b0; ImemReady = 1'b0; ImemValid = 1'b0;
    PCTargetE = 32'd0; ImemRData = 32'd0;
    #3;
    check("rst_instr", InstrD, Nop);
    check("rst_pcd", PCD, 32'd0);
    check("rst_pcplus4", PCPlus4D, 32'd0);
    check("rst_valid", {31'd0, ValidD}, 32'd0);
    check("rst_req", {31'd0, ImemReq}, 32'd0);
    check("rst_addr", ImemAddr, 32'd0);
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("first_req", {31'd0, ImemReq}, 32'd1);
    check("first_addr", ImemAddr, 32'd0);

    // Stray ImemValid in REQ right after reset must be ignored.
    cyc(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    check("stray_valid", {31'd0, ValidD}, 32'd0);
    check("stray_req", {31'd0, ImemReq}, 32'd1);
    cyc(1, 0, 0, 0, 0, 0);
    check("wait_noreq", {31'd0, ImemReq}, 32'd0);
    expect_load(32'h0050_0093, 32'h0);
    cyc(0, 1, 32'h0050_0093, 0, 0, 0);
    check("load1_valid", {31'd0, ValidD}, 32'd1);
    check("load1_addr", ImemAddr, 32'h4);
    check("load1_req", {31'd0, ImemReq}, 32'd1);
    check("wrap_pcd", PCD2, 32'hFFFF_FFFC);
    check("wrap_pcplus4", PCPlus4D2, 32'h0);
    check("wrap_addr", ImemAddr2, 32'h0);
    cyc(1, 0, 0, 0, 0, 0);
    check("bubble_valid", {31'd0, ValidD}, 32'd0);
    check("bubble_instr", InstrD, Nop);
    check("bubble_pcd", PCD, 32'h0);
    expect_load(32'h00A0_0113, 32'h4);
    cyc(0, 1, 32'h00A0_0113, 0, 0, 0);
    check("load2_addr", ImemAddr, 32'h8);

    // Stall while the response arrives: skid, hold, then release.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h0020_81B3, 1, 0, 0);
    check("hold_req", {31'd0, ImemReq}, 32'd0);
    check("hold_addr", ImemAddr, 32'h8);
    check("hold_valid", {31'd0, ValidD}, 32'd0);
    cyc(0, 0, 0, 1, 0, 0);
    check("hold_instr", InstrD, Nop);
    check("hold_pcd", PCD, 32'h4);
    expect_load(32'h0020_81B3, 32'h8);
    cyc(0, 0, 0, 0, 0, 0);
    check("skid_addr", ImemAddr, 32'hC);

    // Flush during WAIT: stale response discarded, fetch resumes at aligned target.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h0000_0103);
    check("flw_instr", InstrD, Nop);
    check("flw_valid", {31'd0, ValidD}, 32'd0);
    check("flw_addr", ImemAddr, 32'h100);
    check("flw_req", {31'd0, ImemReq}, 32'd0);
    cyc(0, 1, 32'hBADB_AD00, 0, 0, 0);
    check("stale_valid", {31'd0, ValidD}, 32'd0);
    check("stale_req", {31'd0, ImemReq}, 32'd1);
    check("stale_addr", ImemAddr, 32'h100);
    cyc(1, 0, 0, 0, 0, 0);
    expect_load(32'h0010_0093, 32'h100);
    cyc(0, 1, 32'h0010_0093, 0, 0, 0);
    check("load4_valid", {31'd0, ValidD}, 32'd1);
    check("load4_addr", ImemAddr, 32'h104);

    // Flush and stall together while a request is accepted: flush wins.
    cyc(1, 0, 0, 1, 1, 32'h0000_0200);
    check("fs_valid", {31'd0, ValidD}, 32'd0);
    check("fs_instr", InstrD, Nop);
    check("fs_addr", ImemAddr, 32'h200);
    check("fs_pcd", PCD, 32'h100);
    check("fs_req", {31'd0, ImemReq}, 32'd0);
    cyc(0, 1, 32'hBADB_AD01, 0, 0, 0);
    check("fs_stale_valid", {31'd0, ValidD}, 32'd0);
    check("fs_stale_addr", ImemAddr, 32'h200);
    check("fs_stale_req", {31'd0, ImemReq}, 32'd1);
    cyc(1, 0, 0, 0, 0, 0);
    expect_load(32'h0000_0033, 32'h200);
    cyc(0, 1, 32'h0000_0033, 0, 0, 0);
    check("load5_addr", ImemAddr, 32'h204);

    // Flush in REQ with no acceptance.
    cyc(0, 0, 0, 0, 1, 32'h0000_0302);
    check("flr_addr", ImemAddr, 32'h300);
    check("flr_req", {31'd0, ImemReq}, 32'd1);
    check("flr_valid", {31'd0, ValidD}, 32'd0);

    // Flush in HOLD discards the skid word.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'hCAFE_0001, 1, 0, 0);
    check("h2_req", {31'd0, ImemReq}, 32'd0);
    cyc(0, 0, 0, 0, 1, 32'h0000_0400);
    check("flh_addr", ImemAddr, 32'h400);
    check("flh_req", {31'd0, ImemReq}, 32'd1);
    check("flh_valid", {31'd0, ValidD}, 32'd0);
    cyc(1, 0, 0, 0, 0, 0);
    expect_load(32'h0040_0493, 32'h400);
    cyc(0, 1, 32'h0040_0493, 0, 0, 0);
    check("load6_addr", ImemAddr, 32'h404);
    cyc(0, 0, 0, 0, 0, 0);
    check("end_valid", {31'd0, ValidD}, 32'd0);
    @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);

`ifdef FETCH_PERF_EN
    check("perf_fetch", FetchCount, exp_fetch);
    check("perf_stall", StallCount, exp_stall);
`endif

    #2 reset = 1'b1;
    #1;
    check("rst2_instr", InstrD, Nop);
    check("rst2_pcd", PCD, 32'd0);
    check("rst2_valid", {31'd0, ValidD}, 32'd0);
    check("rst2_addr", ImemAddr, 32'd0);
`ifdef FETCH_PERF_EN
    check("perf_fetch_rst", FetchCount, 32'd0);
    check("perf_stall_rst", StallCount, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
